// File: rtl/pipeif_fq.sv
// pipeif_fq: instruction-fetch stage with a decoupling fetch queue.
// Owns the fetch PC, picks the next PC (sequential / bpc / da / jpc) and
// issues requests to a 1-cycle-latency instruction memory. Responses are
// buffered in a DEPTH-entry FIFO of {instruction, addr+4}. Any redirect
// flushes the queue and discards the in-flight response.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   pcsource          : 00 seq, 01 bpc, 10 da, 11 jpc (non-00 = redirect)
//   bpc, da, jpc      : redirect targets
//   imem_req/addr     : fetch request to instruction memory
//   imem_rdata        : data for the request of the previous cycle
//   ins, ins_pc4      : queue head (0 when ins_valid=0)
//   ins_valid/ready   : head handshake toward decode
//   count             : queue occupancy
module pipeif_fq #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [1:0]                   pcsource,
    input  logic [ADDR_W-1:0]            bpc,
    input  logic [ADDR_W-1:0]            da,
    input  logic [ADDR_W-1:0]            jpc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_rdata,
    output logic [DATA_W-1:0]            ins,
    output logic [ADDR_W-1:0]            ins_pc4,
    output logic                         ins_valid,
    input  logic                         ins_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] fpc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;

    logic [DATA_W-1:0] q_ins [DEPTH];
    logic [ADDR_W-1:0] q_pc4 [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] tgt;
    logic              pop;
    logic              push;
    logic [CW:0]       occ;
    logic              room;

    always_comb begin
        tgt = bpc;
        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = da;
            2'b11:   tgt = jpc;
            default: tgt = bpc;
        endcase
    end

    assign redirect  = (pcsource != 2'b00);
    assign ins_valid = (cnt != '0);
    assign count     = cnt;

    // A redirect voids both the pop and the arriving response.
    assign pop  = ins_valid & ins_ready & ~redirect;
    assign push = inflight & ~redirect;

    // Credit check counts the in-flight response so the FIFO never overflows.
    assign occ  = {1'b0, cnt} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign room = (occ < (CW+1)'(DEPTH));

    assign imem_req  = ~reset & (redirect | room);
    assign imem_addr = redirect ? tgt : fpc;

    assign ins     = ins_valid ? q_ins[rd_ptr] : '0;
    assign ins_pc4 = ins_valid ? q_pc4[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc           <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
        end else if (redirect) begin
            fpc           <= tgt + ADDR_W'(4);
            inflight      <= 1'b1;
            inflight_addr <= tgt;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            cnt           <= '0;
        end else begin
            if (room) begin
                fpc           <= fpc + ADDR_W'(4);
                inflight      <= 1'b1;
                inflight_addr <= fpc;
            end else begin
                inflight <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            q_ins[wr_ptr] <= imem_rdata;
            q_pc4[wr_ptr] <= inflight_addr + ADDR_W'(4);
        end
    end

endmodule

// File: doc/pipeif_fq.md
# pipeif_fq

Parametrised instruction-fetch stage with a decoupling fetch queue. It replaces the single-shot fetch stage of the pipelined computer. It owns the fetch PC, selects the next PC from sequential/branch/register/jump sources, and issues requests to a synchronous instruction memory with 1-cycle latency. Returned instructions are buffered in a DEPTH-entry FIFO so that decode stalls do not stall fetch. Any redirect flushes the queue and the in-flight fetch.

## Interface
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction width
- DEPTH, 4, fetch-queue entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- pcsource  in  2  next-PC select: 00 sequential, 01 bpc, 10 da, 11 jpc; any non-00 value is a redirect this cycle
- bpc  in  ADDR_W  branch target
- da  in  ADDR_W  register (jr) target
- jpc  in  ADDR_W  jump target
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address; valid while imem_req=1
- imem_rdata  in  DATA_W  instruction for the request issued in the previous cycle
- ins  out  DATA_W  queue head instruction; 0 when ins_valid=0
- ins_pc4  out  ADDR_W  queue head address + 4; 0 when ins_valid=0
- ins_valid  out  1  queue non-empty
- ins_ready  in  1  decode accepts the head; a pop happens when ins_valid & ins_ready
- count  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- State:
  - fpc (ADDR_W): next sequential fetch address.
  - inflight (1 bit) and inflight_addr (ADDR_W): the request issued in the previous cycle.
  - FIFO of DEPTH entries holding {instruction, addr+4}, with rd/wr pointers and count.
- Target select (combinational): tgt = bpc / da / jpc per pcsource. redirect = (pcsource != 00).
- Normal cycle (no redirect):
  - pop = ins_valid & ins_ready.
  - room = (count + inflight - pop) < DEPTH.
  - imem_req = room; imem_addr = fpc.
  - On issue: fpc <= fpc + 4; inflight <= 1; inflight_addr <= fpc. Otherwise inflight <= 0.
  - If inflight=1, push {imem_rdata, inflight_addr + 4}. A push is always accepted; the room rule guarantees space.
  - Push and pop in the same cycle leave count unchanged.
- Redirect cycle:
  - The queue is flushed (count <= 0, pointers reset). Any pop is void.
  - The in-flight response arriving this cycle is discarded.
  - imem_req = 1; imem_addr = tgt. The target is fetched in the same cycle, with no bubble.
  - fpc <= tgt + 4; inflight <= 1; inflight_addr <= tgt.
- Arithmetic: all address adds are modulo 2^ADDR_W, so 0xFFFFFFFC + 4 wraps to 0. Targets are used unaligned-as-given; no masking.
- Reset (synchronous, takes priority over redirect):
  - fpc <= RESET_PC; inflight <= 0; count <= 0; pointers <= 0.
  - Reset outputs: imem_req=0, ins_valid=0, ins=0, ins_pc4=0, count=0.
  - Asserting reset mid-stream drops queued and in-flight instructions.

## Timing
- Cycle 0 is the first cycle with reset low: imem_req=1, imem_addr=RESET_PC.
- Cycle 1: response pushed at the end of the cycle. Cycle 2: ins_valid=1, ins=mem[RESET_PC], ins_pc4=RESET_PC+4.
- Fetch-to-decode latency is 2 cycles. Sustained throughput is 1 instruction/cycle while ins_ready=1, for any DEPTH >= 2.
- Redirect in cycle N:
  - ins_valid=0 in cycle N+1.
  - The target instruction appears at the head in cycle N+2.
  - A second redirect in cycle N+1 supersedes the first; the response for the first target is discarded.
- With ins_ready=0, the queue fills to exactly DEPTH. imem_req then stays 0 until a pop. The credit rule counts the in-flight entry, so the FIFO never overflows.
- count and ins_valid are registered-state derived: they change only at clock edges.

## Test plan
- Reset release, RESET_PC=0x100, ins_ready=1, pcsource=00 -> imem_addr 0x100, 0x104, 0x108… on consecutive cycles; ins_valid from cycle 2 with ins_pc4 = 0x104, 0x108, 0x10C…, no gaps.
- ins_ready=0 from cycle 2, DEPTH=4 -> count climbs to 4 and holds; imem_req=0 once count + inflight = 4. Raise ready -> 4 queued instructions drain in order, then the stream continues gap-free with no lost or duplicated address.
- Redirect with pcsource=01, bpc=0x400 while count=3 -> same cycle imem_addr=0x400; next cycle count=0, ins_valid=0; following cycle ins=mem[0x400], ins_pc4=0x404. The stale in-flight word is never presented.
- Back-to-back redirects jpc=0x200 then da=0x300 -> only mem[0x300] reaches the head; mem[0x200] is never visible.
- Wrap: redirect jpc=0xFFFFFFFC -> next fetch addresses are 0xFFFFFFFC then 0x00000000; ins_pc4=0x00000000 for the first instruction.
- Reset asserted with count=2 and a request in flight -> next cycle ins_valid=0, count=0, imem_req=0. After reset deasserts, fetch restarts at RESET_PC.
